functional_sequencer: RTL and testbench

- Upstream driver for the 2-bit Functional unit. Holds a small program of {A,B,I} operand/instruction triples and issues them to the unit one at a time.
- Each triple is held stable for a settle window, then the unit's 2-bit F result is captured and presented with a valid strobe.
- A start/busy/done handshake lets a controller or bench run a whole program without per-step stimulus.

---
 rtl/functional_sequencer_pkg.sv | 15 +
 rtl/functional_sequencer_if.sv | 39 +++
 rtl/functional_sequencer_prog_mem.sv | 22 ++
 rtl/functional_sequencer.sv | 113 +++++++++++
 tb/tb_functional_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/functional_sequencer_pkg.sv
// Shared types and entry-field layout for functional_sequencer and its program memory.
// Entry layout is {A[5:4], B[3:2], I[1:0]}.
package functional_pkg;
   typedef enum logic [1:0] {IDLE, DRIVE, CAPT, FIN} state_t;

   localparam int OP_W    = 2;
   localparam int ENTRY_W = 3 * OP_W;
   localparam int A_HI    = 5;
   localparam int B_HI    = 3;
   localparam int I_HI    = 1;

   function automatic logic [OP_W-1:0] entry_field(input logic [ENTRY_W-1:0] entry, input int hi);
      return entry[hi -: OP_W];
   endfunction
endpackage

// File: rtl/functional_sequencer_if.sv
// Bus between a controller and functional_sequencer: program load, run handshake,
// Functional-unit operands/result and captured results. Optional acc under FUNCSEQ_ACCUM_EN.
interface functional_sequencer_if #(parameter int DEPTH = 8);
   localparam int AW = $clog2(DEPTH);

   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [5:0]    prog_data;
   logic [AW:0]   prog_len;
   logic          start;
   logic [1:0]    A;
   logic [1:0]    B;
   logic [1:0]    I;
   logic [1:0]    F;
   logic          res_valid;
   logic [1:0]    res_data;
   logic [AW-1:0] res_idx;
   logic          busy;
   logic          done;
`ifdef FUNCSEQ_ACCUM_EN
   logic [AW+2:0] acc;
`endif

   modport master (
      output prog_we, prog_addr, prog_data, prog_len, start, F,
      input  A, B, I, res_valid, res_data, res_idx, busy, done
`ifdef FUNCSEQ_ACCUM_EN
      , acc
`endif
   );

   modport slave (
      input  prog_we, prog_addr, prog_data, prog_len, start, F,
      output A, B, I, res_valid, res_data, res_idx, busy, done
`ifdef FUNCSEQ_ACCUM_EN
      , acc
`endif
   );
endinterface

// File: rtl/functional_sequencer_prog_mem.sv
// Program store for functional_sequencer: DEPTH x 6-bit entries, synchronous write,
// asynchronous read. Contents survive reset.
module funcseq_prog_mem
   import functional_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [ENTRY_W-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [ENTRY_W-1:0]         rdata
);
   logic [ENTRY_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/functional_sequencer.sv
// Drives {A,B,I} triples from a small program into the Functional unit, holds each for
// SETTLE cycles, then captures F. Optional running sum of F under FUNCSEQ_ACCUM_EN.
module functional_sequencer
   import functional_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int SETTLE = 1
) (
   input logic                   clk,
   input logic                   rst_n,
   functional_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int WW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

   state_t             state;
   logic [AW-1:0]      idx;
   logic [LW-1:0]      len;
   logic [WW-1:0]      wcnt;
   logic [LW-1:0]      len_clamp;
   logic [AW-1:0]      raddr;
   logic [ENTRY_W-1:0] rdata;
   logic               mem_we;
   logic               last;

   // Idle reads entry 0 for the first step; in CAPT the next entry is prefetched.
   assign raddr     = (state == IDLE) ? '0 : idx + 1'b1;
   assign mem_we    = bus.prog_we && (state == IDLE);
   assign len_clamp = (bus.prog_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.prog_len;
   assign last      = ({1'b0, idx} == (len - 1'b1));

   funcseq_prog_mem #(.DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (bus.prog_addr),
      .wdata (bus.prog_data),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         len           <= '0;
         wcnt          <= '0;
         bus.A         <= '0;
         bus.B         <= '0;
         bus.I         <= '0;
         bus.res_valid <= 1'b0;
         bus.res_data  <= '0;
         bus.res_idx   <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
`ifdef FUNCSEQ_ACCUM_EN
         bus.acc       <= '0;
`endif
      end else begin
         bus.res_valid <= 1'b0;
         bus.done      <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  len      <= len_clamp;
                  bus.busy <= 1'b1;
`ifdef FUNCSEQ_ACCUM_EN
                  bus.acc  <= '0;
`endif
                  if (len_clamp == '0) begin
                     state <= FIN;
                  end else begin
                     bus.A <= entry_field(rdata, A_HI);
                     bus.B <= entry_field(rdata, B_HI);
                     bus.I <= entry_field(rdata, I_HI);
                     idx   <= '0;
                     wcnt  <= WW'(SETTLE);
                     state <= DRIVE;
                  end
               end
            end
            DRIVE: begin
               wcnt <= wcnt - 1'b1;
               if (wcnt == WW'(1)) state <= CAPT;
            end
            CAPT: begin
               bus.res_data  <= bus.F;
               bus.res_idx   <= idx;
               bus.res_valid <= 1'b1;
`ifdef FUNCSEQ_ACCUM_EN
               bus.acc       <= bus.acc + {{LW{1'b0}}, bus.F};
`endif
               if (last) begin
                  state <= FIN;
               end else begin
                  idx   <= idx + 1'b1;
                  bus.A <= entry_field(rdata, A_HI);
                  bus.B <= entry_field(rdata, B_HI);
                  bus.I <= entry_field(rdata, I_HI);
                  wcnt  <= WW'(SETTLE);
                  state <= DRIVE;
               end
            end
            FIN: begin
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_functional_sequencer.sv
// Scoreboard bench for functional_sequencer with a stub Functional unit F = A^B^I.
module tb_functional_sequencer;
   localparam int DEPTH  = 8;
   localparam int SETTLE = 1;
   localparam int AW     = 3;

   typedef struct {
      int         cyc;
      logic [2:0] idx;
      logic [1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 1'b0;
   logic [5:0] model [DEPTH];
   exp_t res_q [$];
   int   done_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   functional_sequencer_if #(.DEPTH(DEPTH)) bus ();

   functional_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.F = bus.A ^ bus.B ^ bus.I;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [1:0] f_of(input logic [5:0] e);
      return e[5:4] ^ e[3:2] ^ e[1:0];
   endfunction

   // Monitor: every res_valid/done the DUT presents is matched against the queues.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.res_valid === 1'b1) begin
            if (res_q.size() == 0) begin
               check("spurious res_valid", 32'(bus.res_valid), 32'd0);
            end else begin
               exp_t e;
               e = res_q.pop_front();
               check("res_idx", 32'(bus.res_idx), 32'(e.idx));
               check("res_data", 32'(bus.res_data), 32'(e.data));
               check("res cycle", cyc, e.cyc);
            end
         end
         if (bus.done === 1'b1) begin
            check("busy with done", 32'(bus.busy), 32'd0);
            if (done_q.size() == 0) begin
               check("spurious done", 32'(bus.done), 32'd0);
            end else begin
               check("done cycle", cyc, done_q.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input int addr, input logic [5:0] data);
      bus.prog_we   = 1'b1;
      bus.prog_addr = AW'(addr);
      bus.prog_data = data;
      step();
      bus.prog_we   = 1'b0;
      model[addr]   = data;
   endtask

   // Pulses start and queues the expected results from the bench's program model.
   task automatic run(input int len);
      int l;
      int s;
      exp_t e;
      l = (len > DEPTH) ? DEPTH : len;
      bus.prog_len = (AW + 1)'(len);
      bus.start    = 1'b1;
      step();
      bus.start = 1'b0;
      s = cyc;
      for (int i = 0; i < l; i++) begin
         e.cyc  = s + (SETTLE + 1) * (i + 1);
         e.idx  = 3'(i);
         e.data = f_of(model[i]);
         res_q.push_back(e);
      end
      done_q.push_back(s + (SETTLE + 1) * l + 1);
   endtask

   task automatic drain(input int budget, input string name);
      for (int k = 0; k < budget && (res_q.size() != 0 || done_q.size() != 0); k++)
         @(negedge clk);
      check({name, " results left"}, res_q.size(), 32'd0);
      check({name, " done left"}, done_q.size(), 32'd0);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e0;
      bus.prog_we   = 1'b0;
      bus.prog_addr = '0;
      bus.prog_data = '0;
      bus.prog_len  = '0;
      bus.start     = 1'b1;
      rst_n         = 1'b0;
      repeat (2) step();
      check("rst A", 32'(bus.A), 32'd0);
      check("rst B", 32'(bus.B), 32'd0);
      check("rst I", 32'(bus.I), 32'd0);
      check("rst res_valid", 32'(bus.res_valid), 32'd0);
      check("rst res_data", 32'(bus.res_data), 32'd0);
      check("rst res_idx", 32'(bus.res_idx), 32'd0);
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst done", 32'(bus.done), 32'd0);
`ifdef FUNCSEQ_ACCUM_EN
      check("rst acc", 32'(bus.acc), 32'd0);
`endif
      bus.start = 1'b0;
      rst_n     = 1'b1;
      mon_en    = 1'b1;
      step();
      check("idle busy", 32'(bus.busy), 32'd0);

      // Basic run: F values 11, 01, 11.
      write(0, 6'b01_10_00);
      write(1, 6'b11_11_01);
      write(2, 6'b00_01_10);
      write(3, 6'b10_01_11);
      write(4, 6'b11_00_10);
      write(5, 6'b01_01_01);
      write(6, 6'b10_11_00);
      write(7, 6'b11_10_01);
      run(3);
      check("busy during run", 32'(bus.busy), 32'd1);
      drain(40, "basic");
      check("held A", 32'(bus.A), 32'b00);
      check("held B", 32'(bus.B), 32'b01);
      check("held I", 32'(bus.I), 32'b10);
      check("held res_data", 32'(bus.res_data), 32'b11);
      check("held res_idx", 32'(bus.res_idx), 32'd2);
`ifdef FUNCSEQ_ACCUM_EN
      check("acc basic", 32'(bus.acc), 32'd7);
`endif

      // Zero length.
      run(0);
      drain(20, "zero");
      check("zero A", 32'(bus.A), 32'b00);
      check("zero B", 32'(bus.B), 32'b01);
      check("zero I", 32'(bus.I), 32'b10);

      // Length clamp.
      run(12);
      drain(60, "clamp");

      // Mid-run write and start are ignored.
      run(3);
      bus.prog_we   = 1'b1;
      bus.prog_addr = 3'd1;
      bus.prog_data = 6'b00_00_00;
      bus.start     = 1'b1;
      step();
      bus.prog_we = 1'b0;
      bus.start   = 1'b0;
      drain(40, "ignored");
      run(3);
      drain(40, "rerun");

      // Reset during step 1 DRIVE.
      run(3);
      step();
      step();
      e0 = res_q[0];
      res_q.delete();
      res_q.push_back(e0);
      done_q.delete();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("midrst busy", 32'(bus.busy), 32'd0);
      check("midrst A", 32'(bus.A), 32'd0);
      check("midrst B", 32'(bus.B), 32'd0);
      check("midrst I", 32'(bus.I), 32'd0);
      check("midrst done", 32'(bus.done), 32'd0);
      repeat (4) step();
      run(3);
      drain(40, "after reset");

      // Start with a simultaneous write to entry 0: run sees the old entry.
      bus.prog_we   = 1'b1;
      bus.prog_addr = 3'd0;
      bus.prog_data = 6'b01_00_00;
      run(1);
      bus.prog_we = 1'b0;
      model[0]    = 6'b01_00_00;
      drain(20, "start+write");
      run(1);
      drain(20, "new entry0");

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
